rob_regfile: RTL and testbench

Architectural register file and pending-write scoreboard at the register-file end of the ROB↔RF interface. Decode presents up to two instructions per cycle. For each instruction the block returns both source operands one cycle later as `readNM_valid_bit` / `readNM_ready` / `readNM_data`, and marks the instruction's destination as pending. The ROB retires up to two results per cycle on `WB_en1/2`; each retirement writes the register and clears one pending mark.

---
 rtl/rob_regfile.sv | 159 +++++++++++++++
 tb/tb_rob_regfile.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/rob_regfile.sv
// Architectural register file with a per-register pending-write scoreboard.
// Two decode read ports (two sources each) and two ROB retire ports per cycle.
module rob_regfile #(
  parameter int OPRAND_WIDTH  = 32,
  parameter int REGNAME_WIDTH = 5,
  parameter int CNT_WIDTH     = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dec1_valid,
  input  logic [REGNAME_WIDTH-1:0] dec1_src1,
  input  logic [REGNAME_WIDTH-1:0] dec1_src2,
  input  logic                     dec1_dst_en,
  input  logic [REGNAME_WIDTH-1:0] dec1_dst,
  input  logic                     dec2_valid,
  input  logic [REGNAME_WIDTH-1:0] dec2_src1,
  input  logic [REGNAME_WIDTH-1:0] dec2_src2,
  input  logic                     dec2_dst_en,
  input  logic [REGNAME_WIDTH-1:0] dec2_dst,
  output logic                     read11_valid_bit,
  output logic                     read11_ready,
  output logic [OPRAND_WIDTH-1:0]  read11_data,
  output logic                     read12_valid_bit,
  output logic                     read12_ready,
  output logic [OPRAND_WIDTH-1:0]  read12_data,
  output logic                     read21_valid_bit,
  output logic                     read21_ready,
  output logic [OPRAND_WIDTH-1:0]  read21_data,
  output logic                     read22_valid_bit,
  output logic                     read22_ready,
  output logic [OPRAND_WIDTH-1:0]  read22_data,
  input  logic                     WB_en1,
  input  logic [REGNAME_WIDTH-1:0] WB_target1,
  input  logic [OPRAND_WIDTH-1:0]  WB_data1,
  input  logic                     WB_en2,
  input  logic [REGNAME_WIDTH-1:0] WB_target2,
  input  logic [OPRAND_WIDTH-1:0]  WB_data2,
  output logic                     busy_ovf,
  output logic                     busy_unf
);

  localparam int W    = OPRAND_WIDTH;
  localparam int R    = REGNAME_WIDTH;
  localparam int C    = CNT_WIDTH;
  localparam int NREG = 1 << R;
  localparam logic [C+1:0] CMAX = {2'b00, {C{1'b1}}};

  logic [W-1:0] regs    [NREG];
  logic [C-1:0] cnt     [NREG];
  logic [C-1:0] cnt_nxt [NREG];
  logic [C+1:0] up      [NREG];
  logic [C+1:0] dn      [NREG];
  logic [NREG-1:0] mk1, mk2, wb1, wb2;
  logic ovf_any, unf_any;

  logic [R-1:0] src [4];
  logic [3:0]   src_vld;
  logic [3:0]   h1, h2, rdy;
  logic [C:0]   ret [4];
  logic [W-1:0] byp [4];

  logic [3:0]   vb_q, rdy_q;
  logic [W-1:0] dat_q [4];

  assign src[0]  = dec1_src1;
  assign src[1]  = dec1_src2;
  assign src[2]  = dec2_src1;
  assign src[3]  = dec2_src2;
  assign src_vld = {dec2_valid, dec2_valid, dec1_valid, dec1_valid};

  // Write-first operand bypass and readiness net of this cycle's retirements
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      h1[i]  = WB_en1 && (WB_target1 == src[i]);
      h2[i]  = WB_en2 && (WB_target2 == src[i]);
      ret[i] = (C+1)'(h1[i]) + (C+1)'(h2[i]);
      byp[i] = regs[src[i]];
      if (h1[i]) byp[i] = WB_data1;
      if (h2[i]) byp[i] = WB_data2;
      rdy[i] = ({1'b0, cnt[src[i]]} <= ret[i]);
      if (i >= 2 && dec1_valid && dec1_dst_en && dec1_dst == src[i])
        rdy[i] = 1'b0;
      if (src[i] == '0) begin
        byp[i] = '0;
        rdy[i] = 1'b1;
      end
    end
  end

  // Saturating pending counters: +marks, -retirements
  always_comb begin
    ovf_any = 1'b0;
    unf_any = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      mk1[r] = dec1_valid && dec1_dst_en && (dec1_dst == R'(r));
      mk2[r] = dec2_valid && dec2_dst_en && (dec2_dst == R'(r));
      wb1[r] = WB_en1 && (WB_target1 == R'(r));
      wb2[r] = WB_en2 && (WB_target2 == R'(r));
      up[r]  = {2'b00, cnt[r]} + (C+2)'(mk1[r]) + (C+2)'(mk2[r]);
      dn[r]  = (C+2)'(wb1[r]) + (C+2)'(wb2[r]);
      cnt_nxt[r] = cnt[r];
      if (r == 0) begin
        cnt_nxt[r] = '0;
      end else if (up[r] < dn[r]) begin
        cnt_nxt[r] = '0;
        unf_any    = 1'b1;
      end else if ((up[r] - dn[r]) > CMAX) begin
        cnt_nxt[r] = '1;
        ovf_any    = 1'b1;
      end else begin
        cnt_nxt[r] = C'(up[r] - dn[r]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
      busy_ovf <= 1'b0;
      busy_unf <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt[r] <= cnt_nxt[r];
      if (WB_en1 && WB_target1 != '0) regs[WB_target1] <= WB_data1;
      if (WB_en2 && WB_target2 != '0) regs[WB_target2] <= WB_data2;
      busy_ovf <= busy_ovf | ovf_any;
      busy_unf <= busy_unf | unf_any;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vb_q  <= '0;
      rdy_q <= '0;
      for (int i = 0; i < 4; i++) dat_q[i] <= '0;
    end else begin
      vb_q  <= src_vld;
      rdy_q <= src_vld & rdy;
      for (int i = 0; i < 4; i++)
        dat_q[i] <= src_vld[i] ? byp[i] : '0;
    end
  end

  assign read11_valid_bit = vb_q[0];
  assign read12_valid_bit = vb_q[1];
  assign read21_valid_bit = vb_q[2];
  assign read22_valid_bit = vb_q[3];
  assign read11_ready     = rdy_q[0];
  assign read12_ready     = rdy_q[1];
  assign read21_ready     = rdy_q[2];
  assign read22_ready     = rdy_q[3];
  assign read11_data      = dat_q[0];
  assign read12_data      = dat_q[1];
  assign read21_data      = dat_q[2];
  assign read22_data      = dat_q[3];

endmodule

// File: tb/tb_rob_regfile.sv
// Scoreboard bench for rob_regfile: directed bundles push expected
// responses; a monitor pops and compares them one cycle later.
module tb_rob_regfile;

  logic clk = 1'b0;
  logic rst;
  logic dec1_valid, dec1_dst_en, dec2_valid, dec2_dst_en;
  logic [4:0] dec1_src1, dec1_src2, dec1_dst;
  logic [4:0] dec2_src1, dec2_src2, dec2_dst;
  logic read11_valid_bit, read12_valid_bit, read21_valid_bit, read22_valid_bit;
  logic read11_ready, read12_ready, read21_ready, read22_ready;
  logic [31:0] read11_data, read12_data, read21_data, read22_data;
  logic WB_en1, WB_en2;
  logic [4:0] WB_target1, WB_target2;
  logic [31:0] WB_data1, WB_data2;
  logic busy_ovf, busy_unf;

  rob_regfile dut (
    .clk(clk), .rst(rst),
    .dec1_valid(dec1_valid), .dec1_src1(dec1_src1), .dec1_src2(dec1_src2),
    .dec1_dst_en(dec1_dst_en), .dec1_dst(dec1_dst),
    .dec2_valid(dec2_valid), .dec2_src1(dec2_src1), .dec2_src2(dec2_src2),
    .dec2_dst_en(dec2_dst_en), .dec2_dst(dec2_dst),
    .read11_valid_bit(read11_valid_bit), .read11_ready(read11_ready),
    .read11_data(read11_data),
    .read12_valid_bit(read12_valid_bit), .read12_ready(read12_ready),
    .read12_data(read12_data),
    .read21_valid_bit(read21_valid_bit), .read21_ready(read21_ready),
    .read21_data(read21_data),
    .read22_valid_bit(read22_valid_bit), .read22_ready(read22_ready),
    .read22_data(read22_data),
    .WB_en1(WB_en1), .WB_target1(WB_target1), .WB_data1(WB_data1),
    .WB_en2(WB_en2), .WB_target2(WB_target2), .WB_data2(WB_data2),
    .busy_ovf(busy_ovf), .busy_unf(busy_unf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]       vb;
    logic [3:0]       rdy;
    logic [3:0][31:0] d;
    logic             ovf;
    logic             unf;
    logic [31:0]      id;
    logic [31:0]      due;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic eo, eu;
  string nm [4] = '{"read11", "read12", "read21", "read22"};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int id,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step=%0d got=%0h want=%0h", name, id, act, exp);
    end
  endtask

  task automatic cmp_outs(input exp_t x);
    logic [3:0] avb, ardy;
    logic [3:0][31:0] ad;
    avb  = {read22_valid_bit, read21_valid_bit, read12_valid_bit, read11_valid_bit};
    ardy = {read22_ready, read21_ready, read12_ready, read11_ready};
    ad   = {read22_data, read21_data, read12_data, read11_data};
    for (int i = 0; i < 4; i++) begin
      chk({nm[i], "_valid_bit"}, x.id, 32'(avb[i]), 32'(x.vb[i]));
      chk({nm[i], "_ready"}, x.id, 32'(ardy[i]), 32'(x.rdy[i]));
      chk({nm[i], "_data"}, x.id, ad[i], x.d[i]);
    end
    chk("busy_ovf", x.id, 32'(busy_ovf), 32'(x.ovf));
    chk("busy_unf", x.id, 32'(busy_unf), 32'(x.unf));
  endtask

  // Monitor: compare each bundle's response in the cycle it is due
  always @(posedge clk) begin
    #2;
    while (q.size() > 0 && q[0].due <= 32'(cyc)) begin
      exp_t x;
      x = q.pop_front();
      chk("due_cycle", int'(x.id), 32'(cyc), x.due);
      cmp_outs(x);
    end
  end

  task automatic clr();
    dec1_valid = 0; dec1_src1 = 0; dec1_src2 = 0; dec1_dst_en = 0; dec1_dst = 0;
    dec2_valid = 0; dec2_src1 = 0; dec2_src2 = 0; dec2_dst_en = 0; dec2_dst = 0;
    WB_en1 = 0; WB_target1 = 0; WB_data1 = 0;
    WB_en2 = 0; WB_target2 = 0; WB_data2 = 0;
    e = '0;
  endtask

  task automatic rd(input int n, input logic [4:0] s1, input logic [4:0] s2);
    if (n == 1) begin
      dec1_valid = 1; dec1_src1 = s1; dec1_src2 = s2;
      e.vb[0] = 1; e.vb[1] = 1; e.rdy[0] = 1; e.rdy[1] = 1;
    end else begin
      dec2_valid = 1; dec2_src1 = s1; dec2_src2 = s2;
      e.vb[2] = 1; e.vb[3] = 1; e.rdy[2] = 1; e.rdy[3] = 1;
    end
  endtask

  task automatic mark(input int n, input logic [4:0] d);
    if (n == 1) begin
      if (!dec1_valid) rd(1, 0, 0);
      dec1_dst_en = 1; dec1_dst = d;
    end else begin
      if (!dec2_valid) rd(2, 0, 0);
      dec2_dst_en = 1; dec2_dst = d;
    end
  endtask

  task automatic wb(input int k, input logic [4:0] t, input logic [31:0] d);
    if (k == 1) begin
      WB_en1 = 1; WB_target1 = t; WB_data1 = d;
    end else begin
      WB_en2 = 1; WB_target2 = t; WB_data2 = d;
    end
  endtask

  task automatic exp_r(input int i, input logic r, input logic [31:0] d);
    e.rdy[i] = r;
    e.d[i]   = d;
  endtask

  task automatic step(input int id);
    e.ovf = eo;
    e.unf = eu;
    e.id  = 32'(id);
    e.due = 32'(cyc + 1);
    q.push_back(e);
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic check_zero(input int id);
    exp_t z;
    z = '0;
    z.id = 32'(id);
    cmp_outs(z);
  endtask

  initial begin
    clr();
    eo = 0; eu = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    check_zero(0);
    rst = 0;

    rd(1, 3, 0); step(1);
    rd(1, 0, 0); mark(1, 0); wb(1, 0, 32'hFFFF_FFFF); step(2);
    rd(2, 0, 0); step(3);
    rd(1, 0, 0); mark(1, 5); step(4);
    rd(1, 5, 5); exp_r(0, 0, 0); exp_r(1, 0, 0); step(5);
    wb(1, 5, 32'hDEAD_BEEF); rd(2, 5, 0); exp_r(2, 1, 32'hDEAD_BEEF); step(6);
    rd(1, 5, 7); mark(1, 7); rd(2, 1, 7);
    exp_r(0, 1, 32'hDEAD_BEEF); exp_r(3, 0, 0); step(7);
    wb(1, 7, 32'h77); step(8);
    wb(1, 7, 32'h78); eu = 1; step(9);
    mark(1, 9); mark(2, 9); step(10);
    wb(1, 9, 32'h11); wb(2, 9, 32'h22); rd(1, 7, 9);
    exp_r(0, 1, 32'h78); exp_r(1, 1, 32'h22); step(11);
    rd(2, 9, 9); exp_r(2, 1, 32'h22); exp_r(3, 1, 32'h22); step(12);
    mark(1, 4); mark(2, 4); step(13);
    rd(1, 4, 0); mark(1, 4); mark(2, 4); exp_r(0, 0, 0); step(14);
    mark(1, 4); mark(2, 4); step(15);
    mark(1, 4); mark(2, 4); eo = 1; step(16);
    wb(1, 4, 32'h44); rd(1, 4, 0); exp_r(0, 0, 32'h44); step(17);

    @(posedge clk);
    #3;
    rst = 1;
    #1;
    check_zero(18);
    @(posedge clk);
    #1;
    rst = 0;
    eo = 0; eu = 0;

    rd(1, 4, 5); step(19);
    mark(1, 3); rd(2, 3, 3); exp_r(2, 0, 0); exp_r(3, 0, 0); step(20);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d want=0 pending", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
